// File: rtl/i2s_target_pkg.sv
// rtl/i2s_target_pkg.sv - shared sample type and widths for the I2S target port
// Purpose: sample_t {lc,rc} frame exchanged with the pedal datapath, plus
//          counter/index widths used by the I2S target.
package i2s_target_pkg;

    localparam int SAMPLE_W = 24;
    localparam int IDX_W    = $clog2(SAMPLE_W);
    localparam int CNT_W    = 6;

    typedef struct packed {
        logic [SAMPLE_W-1:0] lc;
        logic [SAMPLE_W-1:0] rc;
    } sample_t;

endpackage

// File: rtl/i2s_target_if.sv
// rtl/i2s_target_if.sv - I2S pins and sample handshake bundle for i2s_target
// Purpose: groups the I2S serial pins and the datapath sample ports.
// Signals: sclk/lrck/sdi (from controller), sdo (to controller),
//          rx_data/rx_vld (received frame), tx_data/tx_vld (frame to send),
//          locked, frame_err (status pulses).
// Modports: slave = the I2S target, master = controller/datapath side.
interface i2s_target_if;
    import i2s_target_pkg::*;

    logic    sclk;
    logic    lrck;
    logic    sdi;
    logic    sdo;
    sample_t rx_data;
    logic    rx_vld;
    sample_t tx_data;
    logic    tx_vld;
    logic    locked;
    logic    frame_err;

    modport slave (
        input  sclk, lrck, sdi, tx_data, tx_vld,
        output sdo, rx_data, rx_vld, locked, frame_err
    );

    modport master (
        output sclk, lrck, sdi, tx_data, tx_vld,
        input  sdo, rx_data, rx_vld, locked, frame_err
    );

endinterface

// File: rtl/i2s_target_sync_ff.sv
// rtl/i2s_target_sync_ff.sv - 1-bit multi-flop synchroniser with async reset
// Purpose: brings one asynchronous input into the i_clk domain.
// Ports: i_clk, i_rst_n (async active-low), i_d (async input), o_q (synchronised).
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/i2s_target.sv
// rtl/i2s_target.sv - I2S target port: externally clocked, MSB-first, 1-bit WS delay
// Purpose: samples sdi into {lc,rc} frames and shifts tx frames out on sdo,
//          with sclk/lrck/sdi synchronised into mclk.
// Ports: mclk, rst_n (async active-low), bus (i2s_target_if.slave):
//        sclk, lrck, sdi, sdo, rx_data, rx_vld, tx_data, tx_vld, locked, frame_err.
module i2s_target
    import i2s_target_pkg::*;
#(
    parameter int SLOT_BITS   = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic         mclk,
    input  logic         rst_n,
    i2s_target_if.slave  bus
);

    logic w_sclk_s;
    logic w_lrck_s;
    logic w_sdi_s;

    sync_ff #(.STAGES(SYNC_STAGES)) u_sync_sclk (
        .i_clk(mclk), .i_rst_n(rst_n), .i_d(bus.sclk), .o_q(w_sclk_s)
    );
    sync_ff #(.STAGES(SYNC_STAGES)) u_sync_lrck (
        .i_clk(mclk), .i_rst_n(rst_n), .i_d(bus.lrck), .o_q(w_lrck_s)
    );
    sync_ff #(.STAGES(SYNC_STAGES)) u_sync_sdi (
        .i_clk(mclk), .i_rst_n(rst_n), .i_d(bus.sdi), .o_q(w_sdi_s)
    );

    logic                r_sclk_d;
    logic                r_ws_z;
    logic [CNT_W-1:0]    r_bit_cnt;
    logic [SAMPLE_W-1:0] r_shreg;
    logic [SAMPLE_W-1:0] r_lc_latch;
    logic                r_have_lc;
    logic                r_locked;
    sample_t             r_rx_data;
    logic                r_rx_vld;
    logic                r_frame_err;
    sample_t             r_tx_hold;
    logic [SAMPLE_W-1:0] r_snap_rc;
    logic [SAMPLE_W-1:0] r_tx_sh;
    logic                r_sdo;

    logic                w_rise;
    logic                w_fall;
    logic                w_boundary;
    logic [IDX_W-1:0]    w_bit_idx;
    logic [SAMPLE_W-1:0] w_shreg_in;

    assign w_rise = w_sclk_s & ~r_sclk_d;
    assign w_fall = ~w_sclk_s & r_sclk_d;

    // WS flips one bit before the MSB, so the rise that first sees the new
    // lrck still carries the LSB of the channel held in r_ws_z.
    assign w_boundary = w_rise & (w_lrck_s != r_ws_z);

    assign w_bit_idx = IDX_W'(SAMPLE_W - 1) - r_bit_cnt[IDX_W-1:0];

    // Shift register including the bit arriving on this rise; bits past
    // SAMPLE_W are dropped and missing LSBs stay zero.
    always_comb begin
        w_shreg_in = r_shreg;
        if (r_bit_cnt < CNT_W'(SAMPLE_W)) begin
            w_shreg_in[w_bit_idx] = w_sdi_s;
        end
    end

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            r_sclk_d    <= 1'b0;
            r_ws_z      <= 1'b0;
            r_bit_cnt   <= '0;
            r_shreg     <= '0;
            r_lc_latch  <= '0;
            r_have_lc   <= 1'b0;
            r_locked    <= 1'b0;
            r_rx_data   <= '0;
            r_rx_vld    <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_sclk_d    <= w_sclk_s;
            r_rx_vld    <= 1'b0;
            r_frame_err <= 1'b0;
            if (w_rise) begin
                r_ws_z <= w_lrck_s;
                if (w_boundary) begin
                    if (!r_ws_z) begin
                        r_lc_latch <= w_shreg_in;
                        // A left slot only counts once a boundary has framed its start.
                        r_have_lc  <= r_locked;
                    end else if (r_have_lc) begin
                        r_rx_data <= '{lc: r_lc_latch, rc: w_shreg_in};
                        r_rx_vld  <= 1'b1;
                    end
                    r_frame_err <= r_locked && (r_bit_cnt != CNT_W'(SLOT_BITS - 1));
                    r_locked    <= 1'b1;
                    r_bit_cnt   <= '0;
                    r_shreg     <= '0;
                end else begin
                    r_shreg <= w_shreg_in;
                    if (r_bit_cnt != {CNT_W{1'b1}}) begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end
            end
        end
    end

    // TX: the frame is snapped at the left boundary so lc and rc always come
    // from the same tx_vld write; a write on the boundary cycle lands in the
    // hold register only and goes out with the following frame.
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_hold <= '0;
            r_snap_rc <= '0;
            r_tx_sh   <= '0;
            r_sdo     <= 1'b0;
        end else begin
            if (bus.tx_vld) begin
                r_tx_hold <= bus.tx_data;
            end
            if (w_boundary) begin
                if (!w_lrck_s) begin
                    r_snap_rc <= r_tx_hold.rc;
                    r_tx_sh   <= r_tx_hold.lc;
                end else begin
                    r_tx_sh   <= r_snap_rc;
                end
            end else if (w_fall) begin
                r_sdo   <= r_tx_sh[SAMPLE_W-1];
                r_tx_sh <= {r_tx_sh[SAMPLE_W-2:0], 1'b0};
            end
        end
    end

    assign bus.sdo       = r_sdo;
    assign bus.rx_data   = r_rx_data;
    assign bus.rx_vld    = r_rx_vld;
    assign bus.locked    = r_locked;
    assign bus.frame_err = r_frame_err;

endmodule
